// File: rtl/bit_serial_adder_pkg.sv
// rtl/bit_serial_adder_pkg.sv - shared FSM encodings, default width and add/sub opcodes
package bit_serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int   DEFAULT_WIDTH = 8;
    localparam logic OP_ADD        = 1'b0;
    localparam logic OP_SUB        = 1'b1;

    function automatic logic is_sub(input logic op);
        return op == OP_SUB;
    endfunction

endpackage

// File: rtl/bit_serial_adder_if.sv
// rtl/bit_serial_adder_if.sv - request/result bundle; zero flag present with BIT_SERIAL_ADDER_ZERO_FLAG_EN
interface bit_serial_adder_if
    import bit_serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;
`ifdef BIT_SERIAL_ADDER_ZERO_FLAG_EN
    logic             zero;

    modport master (
        output start, sub, a, b,
        input  busy, done, sum, cout, overflow, zero
    );
    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, cout, overflow, zero
    );
`else
    modport master (
        output start, sub, a, b,
        input  busy, done, sum, cout, overflow
    );
    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, cout, overflow
    );
`endif
endinterface

// File: rtl/bit_serial_adder_fa.sv
// rtl/bit_serial_adder_fa.sv - 1-bit full-adder cell
module bit_serial_adder_fa (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic z,
    output logic cout
);
    assign z    = x ^ y ^ cin;
    assign cout = (x & y) | (cin & (x ^ y));
endmodule

// File: rtl/bit_serial_adder.sv
// rtl/bit_serial_adder.sv - WIDTH-bit serial add/subtract, one bit per cycle LSB first; zero flag with BIT_SERIAL_ADDER_ZERO_FLAG_EN
module bit_serial_adder
    import bit_serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    bit_serial_adder_if.slave bus
);
    localparam int                CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
`ifdef BIT_SERIAL_ADDER_ZERO_FLAG_EN
    logic               zero_q, zero_d;
`endif

    logic fa_z;
    logic fa_cout;

    bit_serial_adder_fa u_fa (
        .x    (opa_q[0]),
        .y    (opb_q[0]),
        .cin  (carry_q),
        .z    (fa_z),
        .cout (fa_cout)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
`ifdef BIT_SERIAL_ADDER_ZERO_FLAG_EN
        zero_d  = zero_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (bus.start) begin
                    // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
                    opa_d   = bus.a;
                    opb_d   = is_sub(bus.sub) ? ~bus.b : bus.b;
                    carry_d = is_sub(bus.sub);
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                opa_d   = opa_q >> 1;
                opb_d   = opb_q >> 1;
                res_d   = {fa_z, res_q[WIDTH-1:1]};
                carry_d = fa_cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    // Results publish only here so sum holds the previous op during RUN.
                    cnt_d   = '0;
                    sum_d   = res_d;
                    cout_d  = fa_cout;
                    ovf_d   = carry_q ^ fa_cout;
`ifdef BIT_SERIAL_ADDER_ZERO_FLAG_EN
                    zero_d  = (res_d == '0);
`endif
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef BIT_SERIAL_ADDER_ZERO_FLAG_EN
            zero_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
`ifdef BIT_SERIAL_ADDER_ZERO_FLAG_EN
            zero_q  <= zero_d;
`endif
        end
    end

    assign bus.busy     = (state_q == ST_RUN);
    assign bus.done     = (state_q == ST_DONE);
    assign bus.sum      = sum_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;
`ifdef BIT_SERIAL_ADDER_ZERO_FLAG_EN
    assign bus.zero     = zero_q;
`endif

endmodule

// File: tb/tb_bit_serial_adder.sv
// tb/tb_bit_serial_adder.sv - self-checking bench for bit_serial_adder with an arithmetic reference model
module tb_bit_serial_adder;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    bit_serial_adder_if #(.WIDTH(W)) bus ();

    bit_serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.sub   = s;
    endtask

    // Counts rising edges from the accept edge up to and including the edge that raises done.
    task automatic wait_done(output int edges, output int busy_cycles);
        edges = 0;
        busy_cycles = 0;
        forever begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            edges++;
            if (bus.busy) busy_cycles++;
            if (bus.done) break;
            if (edges > 40) begin
                check("done_timeout", 32'(edges), 32'(W + 1));
                break;
            end
        end
    endtask

    task automatic expect_result(input string tag, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic s);
        int sa, sb, sr, ur;
        logic [W-1:0] es;
        logic ec, eo;
        sa = $signed(a);
        sb = $signed(b);
        sr = s ? sa - sb : sa + sb;
        ur = s ? int'(a) - int'(b) : int'(a) + int'(b);
        es = W'(ur);
        ec = s ? (ur >= 0) : (ur >= (1 << W));
        eo = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
        check({tag, "_sum"}, 32'(bus.sum), 32'(es));
        check({tag, "_cout"}, 32'(bus.cout), 32'(ec));
        check({tag, "_ovf"}, 32'(bus.overflow), 32'(eo));
`ifdef BIT_SERIAL_ADDER_ZERO_FLAG_EN
        check({tag, "_zero"}, 32'(bus.zero), 32'(es == '0));
`endif
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic s);
        int e, bc;
        logic [W-1:0] held;
        @(negedge clk);
        issue(a, b, s);
        wait_done(e, bc);
        check({tag, "_lat"}, 32'(e), 32'(W + 1));
        check({tag, "_busy"}, 32'(bc), 32'(W));
        expect_result(tag, a, b, s);
        held = bus.sum;
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, 32'(bus.done), 32'd0);
        check({tag, "_hold"}, 32'(bus.sum), 32'(held));
    endtask

    initial begin
        int e, bc, dones;
        logic [W-1:0] ra, rb;
        logic rs;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_sum", 32'(bus.sum), 32'd0);
        check("rst_cout", 32'(bus.cout), 32'd0);
        check("rst_ovf", 32'(bus.overflow), 32'd0);
`ifdef BIT_SERIAL_ADDER_ZERO_FLAG_EN
        check("rst_zero", 32'(bus.zero), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add", 8'h35, 8'h4A, 1'b0);
        run_op("wrap", 8'hFF, 8'h01, 1'b0);
        run_op("sovf", 8'h7F, 8'h01, 1'b0);
        run_op("sub", 8'h10, 8'h20, 1'b1);
        run_op("subeq", 8'h5A, 8'h5A, 1'b1);
        run_op("subneg", 8'h80, 8'h01, 1'b1);

        // start pulsed mid-RUN with different operands must be ignored
        @(negedge clk);
        issue(8'h21, 8'h13, 1'b0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        issue(8'hC0, 8'hC0, 1'b1);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(e, bc);
        expect_result("ign", 8'h21, 8'h13, 1'b0);
        dones = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        check("ign_nodone", 32'(dones), 32'd0);

        // back-to-back: start asserted during the done cycle
        @(negedge clk);
        issue(8'h44, 8'h22, 1'b0);
        wait_done(e, bc);
        expect_result("b2b1", 8'h44, 8'h22, 1'b0);
        issue(8'h03, 8'h09, 1'b1);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("b2b_busy", 32'(bus.busy), 32'd1);
        check("b2b_oldsum", 32'(bus.sum), 32'h66);
        wait_done(e, bc);
        check("b2b_gap", 32'(e + 1), 32'(W + 1));
        expect_result("b2b2", 8'h03, 8'h09, 1'b1);

        // reset during RUN bit 4
        @(negedge clk);
        issue(8'h0F, 8'h0F, 1'b0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mid_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_sum", 32'(bus.sum), 32'd0);
        check("mid_rst_cout", 32'(bus.cout), 32'd1 - 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        check("mid_nodone", 32'(dones), 32'd0);
        run_op("post", 8'h01, 8'h02, 1'b0);

        for (int i = 0; i < 24; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom);
            run_op($sformatf("rnd%0d", i), ra, rb, rs);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck, expected completion");
        $fatal(1);
    end
endmodule
